// File: rtl/tdm_pkg.sv
// Shared definitions for the tdm receive front end and the tdm core.
// Latency: none, types and constants only.
// Backpressure: none.
package tdm_pkg;

    localparam int unsigned TDM_SLOT_W    = 32;
    localparam int unsigned TDM_NUM_SLOTS = 8;
    localparam int unsigned TDM_SLOT_IW   = $clog2(TDM_NUM_SLOTS);

    // Receive framer state: waiting for frame sync, or locked and deserialising.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/tdm_sync_fifo.sv
// Single-clock FIFO, WIDTH x DEPTH (DEPTH power of 2), registered empty flag.
// Latency: a push into an empty FIFO is at the head after that same clk edge.
// Backpressure: push is dropped when full unless a pop happens on the same edge.
module tdm_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        do_pop  = pop_i & ~empty_q;
        do_push = push_i & (~full_o | do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage, pointers (wrap naturally at DEPTH) and occupancy.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = empty_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/tdm_rx_deser.sv
// TDM serial receiver: oversamples sclk/fsin/tdmin, locks to frame sync, deserialises slots MSB-first.
// Latency: word at the FIFO head 3 clk edges after the LSB sclk rising edge at the pin.
// Backpressure: 4-entry FIFO; a word completing while full (and not popping) is dropped with an overflow pulse.
module tdm_rx_deser
    import tdm_pkg::*;
#(
    parameter int unsigned SLOT_W     = TDM_SLOT_W,
    parameter int unsigned NUM_SLOTS  = TDM_NUM_SLOTS,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         enable,
    input  logic                         sclk,
    input  logic                         fsin,
    input  logic                         tdmin,
    output logic [SLOT_W-1:0]            out_data,
    output logic [$clog2(NUM_SLOTS)-1:0] out_slot,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow,
    output logic                         frame_err
);

    localparam int unsigned SLOT_IW = $clog2(NUM_SLOTS);
    localparam int unsigned BCW     = $clog2(SLOT_W) + 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(SLOT_W - 1);

    typedef struct packed {
        logic [SLOT_IW-1:0] slot;
        logic [SLOT_W-1:0]  word;
    } rx_entry_t;

    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic fsin_s1_q, fsin_s2_q;
    logic tdmin_s1_q, tdmin_s2_q;
    logic rise;

    rx_state_e          state_q, state_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SLOT_IW-1:0] slot_cnt_q, slot_cnt_d;
    logic [SLOT_W-1:0]  shreg_q, shreg_d;
    logic [SLOT_W-1:0]  shift_w;
    logic               fs_point;
    logic               frame_err_q, frame_err_d;
    logic               overflow_q, overflow_d;
    logic               word_vld;
    logic               fifo_full;
    logic               fifo_empty;
    rx_entry_t          push_ent;
    rx_entry_t          head_ent;

    // Double-synchronise the serial pins; sclk gets a third stage for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_s3_q  <= 1'b0;
            fsin_s1_q  <= 1'b0;
            fsin_s2_q  <= 1'b0;
            tdmin_s1_q <= 1'b0;
            tdmin_s2_q <= 1'b0;
        end else begin
            sclk_s1_q  <= sclk;
            sclk_s2_q  <= sclk_s1_q;
            sclk_s3_q  <= sclk_s2_q;
            fsin_s1_q  <= fsin;
            fsin_s2_q  <= fsin_s1_q;
            tdmin_s1_q <= tdmin;
            tdmin_s2_q <= tdmin_s1_q;
        end
    end

    assign rise    = sclk_s2_q & ~sclk_s3_q;
    assign shift_w = {shreg_q[SLOT_W-2:0], tdmin_s2_q};
    // Counters only return to 0/0 after the last slot of a frame completes,
    // so this marks the bit where the next frame sync is due.
    assign fs_point = (bit_cnt_q == '0) && (slot_cnt_q == '0);

    // Framer next state: lock on fsin, count bits/slots, emit words, police frame sync.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        word_vld    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && rise && fsin_s2_q) begin
                    state_d    = RUN;
                    shreg_d    = shift_w;
                    bit_cnt_d  = BCW'(1);
                    slot_cnt_d = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    slot_cnt_d = '0;
                end else if (rise) begin
                    if (fs_point && !fsin_s2_q) begin
                        // Missing frame sync: drop lock and wait for the next one.
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                        bit_cnt_d   = '0;
                        slot_cnt_d  = '0;
                    end else if (fsin_s2_q) begin
                        // Frame sync restarts slot 0; off-schedule it also flags an error.
                        frame_err_d = ~fs_point;
                        shreg_d     = shift_w;
                        bit_cnt_d   = BCW'(1);
                        slot_cnt_d  = '0;
                    end else if (bit_cnt_q == BIT_LAST) begin
                        word_vld   = 1'b1;
                        shreg_d    = shift_w;
                        bit_cnt_d  = '0;
                        slot_cnt_d = slot_cnt_q + 1'b1;
                    end else begin
                        shreg_d   = shift_w;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A word is lost only when the FIFO is full and its head is not leaving now.
    assign overflow_d = word_vld & fifo_full & ~(out_ready & out_valid);

    // Framer state, counters, shift register and the pulse flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign push_ent.slot = slot_cnt_q;
    assign push_ent.word = shift_w;

    tdm_sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .push_i     (word_vld),
        .push_dat_i (push_ent),
        .pop_i      (out_ready),
        .pop_dat_o  (head_ent),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head_ent.word;
    assign out_slot  = head_ent.slot;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_rx_deser.sv
module tb_tdm_rx_deser;

    localparam int SLOT_W     = 32;
    localparam int NUM_SLOTS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_BITS = SLOT_W * NUM_SLOTS;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        sclk = 1'b0;
    logic        fsin = 1'b0;
    logic        tdmin = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_slot;
    logic        out_valid;
    logic        overflow;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    // Reference model: frame position, accumulated word, expected output stream.
    logic [63:0] exp_q[$];
    bit          m_locked = 1'b0;
    int          m_pos = 0;
    logic [31:0] m_acc = '0;
    int          exp_ovf = 0, exp_ferr = 0;
    int          ovf_cnt = 0, ferr_cnt = 0, extra_cnt = 0;

    tdm_rx_deser #(
        .SLOT_W     (SLOT_W),
        .NUM_SLOTS  (NUM_SLOTS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .sclk      (sclk),
        .fsin      (fsin),
        .tdmin     (tdmin),
        .out_data  (out_data),
        .out_slot  (out_slot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #1 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One serial bit as the receiver should interpret it, using frame position arithmetic.
    function automatic void model_bit(input bit fs, input bit d, input bit coincide);
        if (!enable) begin
            m_locked = 1'b0;
            return;
        end
        if (!m_locked) begin
            if (!fs) return;
            m_locked = 1'b1;
            m_pos    = 0;
        end else if (fs) begin
            if (m_pos != FRAME_BITS) exp_ferr++;
            m_pos = 0;
        end else if (m_pos == FRAME_BITS) begin
            exp_ferr++;
            m_locked = 1'b0;
            return;
        end
        m_acc = {m_acc[SLOT_W-2:0], d};
        m_pos++;
        if (m_pos % SLOT_W == 0) begin
            if (exp_q.size() >= FIFO_DEPTH && !coincide) exp_ovf++;
            else exp_q.push_back({29'd0, 3'(m_pos / SLOT_W - 1), m_acc});
        end
    endfunction

    function automatic void model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        exp_q.delete();
    endfunction

    // Observes the DUT for the coming posedge (inputs already set), then advances to the next negedge.
    task automatic tick();
        logic [63:0] obs;
        if (rstn) begin
            if (overflow) ovf_cnt++;
            if (frame_err) ferr_cnt++;
            if (out_valid && out_ready) begin
                obs = {29'd0, out_slot, out_data};
                if (exp_q.size() == 0) extra_cnt++;
                else chk("word", obs, exp_q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    // One sclk period (8 clk). With pop_on_push, out_ready is high only on the push edge.
    task automatic send_bit(input bit fs, input bit d, input bit pop_on_push);
        model_bit(fs, d, pop_on_push);
        sclk  = 1'b0;
        fsin  = fs;
        tdmin = d;
        repeat (4) tick();
        sclk = 1'b1;
        if (pop_on_push) begin
            tick();
            tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            tick();
        end else begin
            repeat (4) tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit fs_first, input bit pop_last);
        for (int i = SLOT_W - 1; i >= 0; i--) begin
            send_bit(fs_first && (i == SLOT_W - 1), w[i], pop_last && (i == 0));
        end
    endtask

    task automatic send_slots(input int n, input bit pat);
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            w = pat ? (32'hA500_0000 + 32'(k)) : 32'($urandom());
            send_word(w, k == 0, 1'b0);
        end
    endtask

    task automatic send_noise(input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'b0, 1'($urandom()), 1'b0);
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        repeat (10) tick();
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_ovf"}, ovf_cnt, exp_ovf);
        chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
        chk({tag, "_extra"}, extra_cnt, 0);
    endtask

    initial begin
        repeat (4) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_slot", out_slot, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        rstn      = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();

        // Two clean frames with a recognisable pattern.
        send_slots(8, 1'b1);
        send_slots(8, 1'b1);
        drain("s1");

        // Consumer stalled for a whole frame: four held, four dropped.
        out_ready = 1'b0;
        send_slots(8, 1'b0);
        chk("s2_valid", out_valid, 1);
        chk("s2_head", {29'd0, out_slot, out_data}, exp_q[0]);
        chk("s2_ovf", ovf_cnt, exp_ovf);
        drain("s2");

        // Early frame sync in slot 2, after ten bits.
        send_slots(2, 1'b0);
        send_noise(10);
        send_slots(8, 1'b0);
        drain("s3");

        // Frame sync missing after slot 7, then a fresh frame.
        send_slots(8, 1'b0);
        send_noise(40);
        send_slots(8, 1'b0);
        drain("s4");

        // Full FIFO, head popped on the very edge the next word is pushed.
        out_ready = 1'b0;
        send_slots(4, 1'b0);
        send_word(32'($urandom()), 1'b0, 1'b1);
        chk("s6_valid", out_valid, 1);
        chk("s6_head", {29'd0, out_slot, out_data}, exp_q[0]);
        chk("s6_ovf", ovf_cnt, exp_ovf);
        drain("s6");

        // Disable mid-frame: capture stops, buffered words still drain.
        out_ready = 1'b0;
        send_slots(3, 1'b0);
        send_noise(7);
        enable    = 1'b0;
        out_ready = 1'b1;
        send_noise(20);
        chk("en_drained", out_valid, 0);
        enable = 1'b1;
        send_noise(10);
        send_slots(8, 1'b0);
        drain("en");

        // Asynchronous reset mid-frame with words buffered.
        out_ready = 1'b0;
        send_slots(3, 1'b0);
        send_noise(5);
        rstn = 1'b0;
        sclk = 1'b0;
        fsin = 1'b0;
        model_reset();
        #1;
        chk("s5_valid", out_valid, 0);
        chk("s5_data", out_data, 0);
        chk("s5_slot", out_slot, 0);
        chk("s5_ovf", overflow, 0);
        chk("s5_ferr", frame_err, 0);
        repeat (3) tick();
        rstn      = 1'b1;
        out_ready = 1'b1;
        send_noise(20);
        send_slots(8, 1'b0);
        drain("s5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
